// File: rtl/dca_matrix_register_sequencer_if.sv
// Row-stream and matrix-register control bundle for the matrix register sequencer.
// master = the sequencer itself; slave = the surrounding row source/sink and register.
interface dca_matrix_register_sequencer_if #(
  parameter int MATRIX_SIZE      = 8,
  parameter int BW_TENSOR_SCALAR = 32
);
  localparam int BW_ROW = MATRIX_SIZE * BW_TENSOR_SCALAR;

  logic              in_valid;
  logic              in_ready;
  logic [BW_ROW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [BW_ROW-1:0] out_data;
  logic              mreg_init;
  logic              mreg_move_wenable;
  logic [BW_ROW-1:0] mreg_move_wdata_list;
  logic              mreg_shift_up;
  logic              mreg_transpose;
  logic [BW_ROW-1:0] mreg_upmost_rdata_list1d;

  modport master (
    input  in_valid, in_data, out_ready, mreg_upmost_rdata_list1d,
    output in_ready, out_valid, out_data, mreg_init, mreg_move_wenable,
           mreg_move_wdata_list, mreg_shift_up, mreg_transpose
  );

  modport slave (
    output in_valid, in_data, out_ready, mreg_upmost_rdata_list1d,
    input  in_ready, out_valid, out_data, mreg_init, mreg_move_wenable,
           mreg_move_wdata_list, mreg_shift_up, mreg_transpose
  );
endinterface

// File: rtl/dca_matrix_register_sequencer.sv
// Sequences one square matrix register through load -> optional transpose -> drain,
// owning all of its control pins and bridging them to valid/ready row streams.
module dca_matrix_register_sequencer #(
  parameter int MATRIX_SIZE      = 8,
  parameter int BW_TENSOR_SCALAR = 32
) (
  input  logic clk,
  input  logic rstnn,
  input  logic start,
  input  logic start_transpose,
  input  logic clear,
  output logic busy,
  output logic done,
  dca_matrix_register_sequencer_if.master bus
);
  localparam int BW_ROW = MATRIX_SIZE * BW_TENSOR_SCALAR;
  localparam int BW_CNT = $clog2(MATRIX_SIZE + 1);
  localparam logic [BW_CNT-1:0] LAST_ROW = BW_CNT'(MATRIX_SIZE - 1);
  localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_XPOSE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BW_CNT-1:0] r_cnt;
  logic [BW_CNT-1:0] w_cnt_nxt;
  logic              r_xp;
  logic              w_xp_nxt;
  logic              r_init_p1;
  logic              r_wen_p1;
  logic              r_done_p1;
  logic [BW_ROW-1:0] r_wdata_p1;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_last;

  // In the first LOAD cycle the init pulse is still in flight, so rows are held off.
  assign bus.in_ready  = (r_state == S_LOAD) & ~r_init_p1;
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.out_data  = bus.out_valid ? bus.mreg_upmost_rdata_list1d : '0;

  assign w_in_hs  = bus.in_valid & bus.in_ready;
  assign w_out_hs = bus.out_valid & bus.out_ready;
  assign w_last   = (r_cnt == LAST_ROW);

  assign busy                     = (r_state != S_IDLE);
  assign done                     = r_done_p1;
  assign bus.mreg_init            = r_init_p1;
  assign bus.mreg_move_wenable    = r_wen_p1;
  assign bus.mreg_move_wdata_list = r_wdata_p1;
  assign bus.mreg_shift_up        = w_out_hs;
  assign bus.mreg_transpose       = (r_state == S_XPOSE);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_xp    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_xp    <= w_xp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_xp_nxt    = r_xp;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
            w_xp_nxt    = start_transpose;
          end
        end
        S_LOAD: begin
          if (w_in_hs) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (w_last) w_state_nxt = S_SETTLE;
          end
        end
        S_SETTLE: begin
          w_state_nxt = r_xp ? S_XPOSE : S_DRAIN;
          w_cnt_nxt   = '0;
        end
        S_XPOSE: begin
          w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Stage p1: register-side pulses land one cycle after the event that caused them.
  // clear re-initialises the register and squashes any write or done still pending.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_init_p1  <= 1'b0;
      r_wen_p1   <= 1'b0;
      r_done_p1  <= 1'b0;
      r_wdata_p1 <= '0;
    end else begin
      r_init_p1 <= clear | ((r_state == S_IDLE) & start);
      r_wen_p1  <= w_in_hs & ~clear;
      r_done_p1 <= (r_state == S_DRAIN) & w_out_hs & w_last & ~clear;
      if (w_in_hs) r_wdata_p1 <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_dca_matrix_register_sequencer.sv
// Self-checking bench: a table of directed jobs plus random jobs, checked against a
// behavioural matrix-register mock and per-cycle protocol rules.
module tb_dca_matrix_register_sequencer;
  localparam int N      = 4;
  localparam int W      = 8;
  localparam int BW_ROW = N * W;

  typedef logic [BW_ROW-1:0] row_t;
  typedef row_t mat_t [N];

  typedef struct {
    bit    xp;
    int    in_mode;   // 0 always valid, 1 one row per 3 cycles, 2 random
    int    out_mode;  // 0 always ready, 1 pattern 1,0,0, 2 random
    int    exp_lat;   // start-to-done cycles, or -1 when stall-dependent
    bit    start_at_done;
    string tag;
  } vec_t;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  logic start = 1'b0;
  logic start_transpose = 1'b0;
  logic clear = 1'b0;
  logic busy;
  logic done;

  dca_matrix_register_sequencer_if #(.MATRIX_SIZE(N), .BW_TENSOR_SCALAR(W)) bus ();

  dca_matrix_register_sequencer #(.MATRIX_SIZE(N), .BW_TENSOR_SCALAR(W)) dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .start           (start),
    .start_transpose (start_transpose),
    .clear           (clear),
    .busy            (busy),
    .done            (done),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural matrix register: rows shift in from the bottom, row 0 is upmost.
  row_t mrow [N];
  assign bus.mreg_upmost_rdata_list1d = mrow[0];

  always @(posedge clk) begin
    if (bus.mreg_init) begin
      for (int i = 0; i < N; i++) mrow[i] <= '0;
    end else if (bus.mreg_move_wenable) begin
      for (int i = 0; i < N - 1; i++) mrow[i] <= mrow[i+1];
      mrow[N-1] <= bus.mreg_move_wdata_list;
    end else if (bus.mreg_shift_up) begin
      for (int i = 0; i < N - 1; i++) mrow[i] <= mrow[i+1];
      mrow[N-1] <= '0;
    end else if (bus.mreg_transpose) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mrow[r][c*W +: W] <= mrow[c][r*W +: W];
    end
  end

  // Per-cycle protocol monitor and event recorder.
  int   n_wen, n_shift, n_xp, n_init, n_done;
  row_t wq[$];
  row_t oq[$];
  logic p_in_hs, p_clear, p_stall;
  row_t p_in_data, p_out_data;

  always @(negedge clk) begin
    if (!rstnn) begin
      p_in_hs = 1'b0;
      p_clear = 1'b0;
      p_stall = 1'b0;
    end else begin
      chk("mutex", ($countones({bus.mreg_move_wenable, bus.mreg_shift_up,
                                bus.mreg_transpose, bus.mreg_init}) <= 1), 1);
      chk("wen_timing", bus.mreg_move_wenable, p_in_hs & ~p_clear);
      if (bus.mreg_move_wenable) chk("wen_data", bus.mreg_move_wdata_list, p_in_data);
      if (bus.mreg_init) chk("ready_in_init", bus.in_ready, 0);
      chk("shift_eq_hs", bus.mreg_shift_up, bus.out_valid & bus.out_ready);
      if (p_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, p_out_data);
      end
      if (bus.mreg_move_wenable) begin n_wen++; wq.push_back(bus.mreg_move_wdata_list); end
      if (bus.mreg_shift_up) n_shift++;
      if (bus.mreg_transpose) n_xp++;
      if (bus.mreg_init) n_init++;
      if (done) n_done++;
      if (bus.out_valid && bus.out_ready) oq.push_back(bus.out_data);
      p_in_hs    = bus.in_valid & bus.in_ready;
      p_in_data  = bus.in_data;
      p_clear    = clear;
      p_stall    = bus.out_valid & ~bus.out_ready & ~clear;
      p_out_data = bus.out_data;
    end
  end

  task automatic clr_counts();
    n_wen = 0; n_shift = 0; n_xp = 0; n_init = 0; n_done = 0;
    wq.delete();
    oq.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input bit xp, input int im, input int om, input mat_t rows,
                         input int exp_lat, input bit sad, input string tag);
    mat_t expm;
    int   sent = 0, gap = 0, dcyc = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
    bit   pend = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        expm[r][c*W +: W] = xp ? rows[c][r*W +: W] : rows[r][c*W +: W];
    clr_counts();
    start = 1'b1;
    start_transpose = xp;
    tick();
    for (int c = 1; c < 400; c++) begin
      if (!pend) begin
        if (gap > 0) begin
          gap--;
          bus.in_valid = 1'b0;
        end else begin
          bus.in_valid = (sent < N) && (im != 2 || $urandom_range(0, 2) != 0);
        end
      end
      bus.in_data   = rows[(sent < N) ? sent : N - 1];
      bus.out_ready = (om == 0) ? 1'b1 : (om == 1) ? (dcyc % 3 == 0) : 1'($urandom_range(0, 1));
      start = (sad && c == exp_lat) || (im == 2 && sent < N && $urandom_range(0, 3) == 0);
      start_transpose = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        pend = 1'b0;
        gap  = (im == 1) ? 2 : 0;
      end else begin
        pend = bus.in_valid;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) last_hs = c;
        dcyc++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (sad && done_cyc >= 0 && c == done_cyc + 1) begin
        chk({tag, "_restart_busy"}, busy, 1);
        chk({tag, "_restart_init"}, bus.mreg_init, 1);
      end
      tick();
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    start_transpose = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (exp_lat > 0) chk({tag, "_latency"}, done_cyc, exp_lat);
    chk({tag, "_done_after_hs"}, done_cyc, last_hs + 1);
    chk({tag, "_wen_cnt"}, n_wen, N);
    chk({tag, "_shift_cnt"}, n_shift, N);
    chk({tag, "_xpose_cnt"}, n_xp, xp);
    chk({tag, "_init_cnt"}, n_init, 1 + sad);
    chk({tag, "_out_cnt"}, oq.size(), N);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_wr_row"}, (i < wq.size()) ? wq[i] : 'x, rows[i]);
      chk({tag, "_out_row"}, (i < oq.size()) ? oq[i] : 'x, expm[i]);
    end
    if (sad) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
    end
    repeat (2) tick();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ctrl"}, {busy, done, bus.in_ready, bus.out_valid, bus.mreg_init,
                        bus.mreg_move_wenable, bus.mreg_shift_up, bus.mreg_transpose}, 0);
    chk({nm, "_wdata"}, bus.mreg_move_wdata_list, 0);
    chk({nm, "_odata"}, bus.out_data, 0);
  endtask

  vec_t tbl [6];
  mat_t m;

  initial begin
    tbl[0] = '{0, 0, 0, 11, 0, "plain"};
    tbl[1] = '{1, 0, 0, 12, 0, "xpose"};
    tbl[2] = '{0, 0, 1, -1, 0, "oready"};
    tbl[3] = '{0, 1, 0, -1, 0, "ingap"};
    tbl[4] = '{1, 1, 1, -1, 0, "both"};
    tbl[5] = '{0, 0, 0, 11, 1, "startdone"};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c*W +: W] = 8'(16 * r + c + 1);

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstnn = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset");
    tick();

    for (int i = 0; i < 6; i++)
      run_job(tbl[i].xp, tbl[i].in_mode, tbl[i].out_mode, m,
              tbl[i].exp_lat, tbl[i].start_at_done, tbl[i].tag);

    // clear after two input rows
    begin
      int k = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20 && k < 2; c++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = m[k];
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) k++;
        tick();
      end
      chk("clr_rows_in", k, 2);
      bus.in_valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      clr_counts();
      @(negedge clk);
      chk("clr_busy", busy, 0);
      chk("clr_init", bus.mreg_init, 1);
      repeat (8) tick();
      chk("clr_no_wen", n_wen, 0);
      chk("clr_no_done", n_done, 0);
      chk("clr_init_cnt", n_init, 1);
    end
    run_job(0, 0, 0, m, 11, 0, "after_clr");

    // clear and start together in IDLE
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    chk("clrstart_busy", busy, 0);
    chk("clrstart_init", bus.mreg_init, 1);
    repeat (2) tick();

    // asynchronous reset in DRAIN
    begin
      int k = 0;
      bit seen = 0;
      bus.out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        bus.in_valid = (k < N);
        bus.in_data  = m[(k < N) ? k : N - 1];
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) k++;
        if (bus.out_valid) seen = 1'b1;
        tick();
      end
      bus.in_valid = 1'b0;
      chk("rst_reached_drain", seen, 1);
      #2 rstnn = 1'b0;
      #1 chk_idle_outputs("async_rst");
      repeat (2) tick();
      rstnn = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_rst");
      tick();
    end
    run_job(1, 0, 0, m, 12, 0, "after_rst");

    for (int j = 0; j < 6; j++) begin
      mat_t rm;
      for (int r = 0; r < N; r++) rm[r] = $urandom;
      run_job(1'($urandom_range(0, 1)), 2, 2, rm, -1, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/dca_matrix_register_sequencer.md
Name: dca_matrix_register_sequencer

Overview:
- Control block that sequences one square matrix register (MATRIX_SIZE x MATRIX_SIZE scalars) through a load → optional transpose → drain job.
- Accepts rows on a valid/ready input stream and writes each one into the register's move port.
- Optionally issues a single transpose, then streams the upmost row out on a valid/ready output stream, shifting up after each output handshake.
- Sits between a DCA tensor row stream (DMA/engine side) and a matrix register instance; it owns all of that register's control pins.

Parameters:
- MATRIX_SIZE, 8: rows = columns of the controlled matrix register; must be ≥ 2.
- BW_TENSOR_SCALAR, 32: scalar width in bits.
- BW_ROW (local), MATRIX_SIZE*BW_TENSOR_SCALAR: row width.
- BW_CNT (local), clog2(MATRIX_SIZE+1): row counter width.

Ports:
- clk  in  1  clock.
- rstnn  in  1  reset, asynchronous assert, active-low.
- start  in  1  job request; sampled in IDLE only.
- start_transpose  in  1  sampled with start; 1 = transpose after load.
- clear  in  1  synchronous abort, higher priority than all other inputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- in_valid  in  1  input row valid.
- in_ready  out  1  input row ready.
- in_data  in  BW_ROW  input row.
- out_valid  out  1  output row valid.
- out_ready  in  1  output row ready.
- out_data  out  BW_ROW  output row.
- mreg_init  out  1  drives register init.
- mreg_move_wenable  out  1  drives register move_wenable.
- mreg_move_wdata_list  out  BW_ROW  drives register move_wdata_list.
- mreg_shift_up  out  1  drives register shift_up.
- mreg_transpose  out  1  drives register transpose.
- mreg_upmost_rdata_list1d  in  BW_ROW  register upmost row.
- Register pins not listed here (move_renable, all_wenable, shift_left) are tied to 0 by the instantiating level.

Behaviour:
- FSM states: IDLE, LOAD, SETTLE, XPOSE, DRAIN. Row counter cnt. Flag xp_r latches start_transpose.
- Reset: state=IDLE, cnt=0, xp_r=0. All outputs 0, including registered mreg_move_wdata_list.
- IDLE:
  - start=1 → LOAD, cnt=0, xp_r=start_transpose.
  - mreg_init pulses for 1 cycle, registered, in the first LOAD cycle.
- LOAD:
  - in_ready=1, except in the first cycle, where init is in flight and in_ready=0.
  - Each in_valid&in_ready handshake: next cycle mreg_move_wenable=1 for exactly 1 cycle and mreg_move_wdata_list=in_data (registered; 1-cycle latency); cnt++.
  - Handshake with cnt==MATRIX_SIZE-1 → SETTLE; in_ready=0 from then on.
- SETTLE: 1 cycle, lets the last write land → XPOSE if xp_r, else DRAIN; cnt=0.
- XPOSE: mreg_transpose=1 for exactly 1 cycle (Moore output) → DRAIN.
- DRAIN:
  - out_valid=1; out_data=mreg_upmost_rdata_list1d (combinational pass-through).
  - mreg_shift_up = out_valid&out_ready (same cycle); cnt++ per handshake.
  - Handshake with cnt==MATRIX_SIZE-1 → IDLE; done=1 in the following cycle (registered).
  - out_valid drops to 0 in that IDLE cycle.
- Backpressure: out_ready=0 holds out_valid and out_data stable, with no shift. in_valid=0 stalls LOAD indefinitely with no timeout.
- start while busy: ignored; no queuing.
- start in the same cycle as the done pulse: accepted, since state is IDLE.
- clear in any state:
  - Next state IDLE, cnt=0.
  - Pending mreg_move_wenable and done are suppressed.
  - mreg_init pulses 1 cycle after clear so the register contents are discarded.
  - clear in IDLE also pulses mreg_init.
- clear with start in the same cycle: clear wins; start is dropped.
- Asynchronous reset mid-job: immediate return to IDLE with all outputs 0; no done pulse.
- Throughput: MATRIX_SIZE rows in and out at 1 row/cycle when unstalled. Start-to-done latency with no stalls = 1 (init) + MATRIX_SIZE + 1 (settle) + xp_r + MATRIX_SIZE + 1 cycles.
- Mutual exclusion: mreg_move_wenable, mreg_shift_up, mreg_transpose and mreg_init are never asserted in the same cycle.

Test Plan:
- MATRIX_SIZE=4, start_transpose=0, rows 0x..01..04 streamed, out_ready=1:
  - 4 mreg_move_wenable pulses, each 1 cycle after its handshake.
  - No transpose pulse.
  - 4 out handshakes with 4 mreg_shift_up pulses.
  - done exactly 11 cycles after start.
- Same job with start_transpose=1: exactly one mreg_transpose pulse, in the cycle after SETTLE; done at 12 cycles.
- out_ready toggled 1,0,0,1,...: out_data constant while stalled; mreg_shift_up count = 4; done only after the 4th handshake.
- in_valid gapped (1 of every 3 cycles): in_ready=0 in the init cycle; exactly 4 writes with data order preserved; no write pulse while stalled.
- clear asserted after 2 input rows: busy=0 next cycle; mreg_init pulse; no further mreg_move_wenable; no done. A following start runs a full clean job.
- rstnn asserted low in DRAIN: all outputs 0 asynchronously. After release, start behaves as from power-up.
